// File: rtl/motor_pkg.sv
// ---------------------------------------------------------------------------
// motor_pkg
// Shared types and default constants for the H-bridge motor drive path.
//   motor_state_e          : drive FSM state, encoding visible on state_o
//   CLK_FREQ_HZ            : system clock frequency
//   PWM_FREQ_HZ            : nominal PWM carrier frequency
//   DEFAULT_PERIOD         : PWM period in clk cycles
//   DEFAULT_RAMP_STEP      : largest duty change allowed per PWM period
//   DEFAULT_DEADTIME_PERIODS : coast periods forced before a reversal
// ---------------------------------------------------------------------------
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        RAMP_DOWN = 2'd2,
        COAST     = 2'd3
    } motor_state_e;

    localparam int CLK_FREQ_HZ              = 100_000_000;
    localparam int PWM_FREQ_HZ              = 20_000;
    localparam int DEFAULT_PERIOD           = CLK_FREQ_HZ / PWM_FREQ_HZ;
    localparam int DEFAULT_RAMP_STEP        = 25;
    // 200 periods of 50 us gives 10 ms of coast before a reversal.
    localparam int DEFAULT_DEADTIME_PERIODS = 200;

endpackage

// File: rtl/pwm_timebase.sv
// ---------------------------------------------------------------------------
// pwm_timebase
// Free-running PWM period counter.
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   cnt_o         out  period position, 0..PERIOD-1, wraps to 0
//   period_tick_o out  high for exactly the last cycle of each period
// ---------------------------------------------------------------------------
module pwm_timebase #(
    parameter int PERIOD = 5000,
    parameter int CNT_W  = $clog2(PERIOD)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt_o,
    output logic             period_tick_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Decoded straight from the counter so the tick lines up with
    // cnt == PERIOD-1 in the same cycle; the following edge is the boundary.
    assign cnt_o         = cnt_q;
    assign period_tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/hbridge_ramp_driver.sv
// ---------------------------------------------------------------------------
// hbridge_ramp_driver
// Drives an L298-style H-bridge with a slew-limited PWM duty, updating duty
// only at PWM period boundaries and forcing a ramp-down plus coast dead-time
// before any change of rotation direction.
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   enable       in   run request (level, already synchronised)
//   direction    in   1 = in3 high, 0 = in4 high
//   speed        in   requested duty in clk counts (clamped to PERIOD-1)
//   motor_in3    out  bridge input 3, registered
//   motor_in4    out  bridge input 4, registered
//   motor_enb    out  bridge PWM enable, registered
//   duty_applied out  duty currently in force
//   period_tick  out  pulse on the last cycle of each PWM period
//   state_o      out  FSM state (IDLE=0, RUN=1, RAMP_DOWN=2, COAST=3)
// ---------------------------------------------------------------------------
module hbridge_ramp_driver
    import motor_pkg::*;
#(
    parameter int PERIOD           = DEFAULT_PERIOD,
    parameter int SPEED_W          = $clog2(PERIOD),
    parameter int RAMP_STEP        = DEFAULT_RAMP_STEP,
    parameter int DEADTIME_PERIODS = DEFAULT_DEADTIME_PERIODS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               direction,
    input  logic [SPEED_W-1:0] speed,
    output logic               motor_in3,
    output logic               motor_in4,
    output logic               motor_enb,
    output logic [SPEED_W-1:0] duty_applied,
    output logic               period_tick,
    output logic [1:0]         state_o
);

    localparam int EXT_W = SPEED_W + 1;
    localparam int CW    = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;

    localparam logic [SPEED_W-1:0] DUTY_MAX   = SPEED_W'(PERIOD - 1);
    localparam logic [EXT_W-1:0]   STEP_X     = EXT_W'(RAMP_STEP);
    localparam logic [CW-1:0]      COAST_LAST = CW'(DEADTIME_PERIODS - 1);

    logic [SPEED_W-1:0] cnt;
    logic               tick;

    motor_state_e       state_q, state_d;
    logic               dir_q, dir_d;
    logic [SPEED_W-1:0] duty_q, duty_d;
    logic [CW-1:0]      coast_q, coast_d;
    logic               in3_q, in4_q, enb_q;

    logic [SPEED_W-1:0] target;
    logic [EXT_W-1:0]   duty_x, target_x, diff_x;
    logic [SPEED_W-1:0] run_duty;
    logic [SPEED_W-1:0] down_duty;
    logic               down_to_zero;
    logic               drive_d;

    pwm_timebase #(
        .PERIOD (PERIOD),
        .CNT_W  (SPEED_W)
    ) u_timebase (
        .clk           (clk),
        .rst           (rst),
        .cnt_o         (cnt),
        .period_tick_o (tick)
    );

    // Candidate duties for the next boundary. One extra bit keeps the
    // up/down arithmetic from wrapping at either end of the range.
    always_comb begin
        target       = (speed > DUTY_MAX) ? DUTY_MAX : speed;
        duty_x       = {1'b0, duty_q};
        target_x     = {1'b0, target};
        diff_x       = '0;
        run_duty     = duty_q;
        if (target_x >= duty_x) begin
            diff_x   = target_x - duty_x;
            run_duty = (diff_x > STEP_X) ? SPEED_W'(duty_x + STEP_X) : target;
        end else begin
            diff_x   = duty_x - target_x;
            run_duty = (diff_x > STEP_X) ? SPEED_W'(duty_x - STEP_X) : target;
        end
        down_to_zero = (duty_x <= STEP_X);
        down_duty    = down_to_zero ? '0 : SPEED_W'(duty_x - STEP_X);
    end

    // Next-state logic. Duty only ever moves on a period tick, so the new
    // value takes effect from cnt == 0 and the PWM never glitches mid-period.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        coast_d = coast_q;
        case (state_q)
            IDLE: begin
                duty_d  = '0;
                coast_d = '0;
                if (enable) begin
                    state_d = RUN;
                    dir_d   = direction;
                end
            end
            RUN: begin
                if (tick) begin
                    duty_d = run_duty;
                end
                if (!enable || (direction != dir_q)) begin
                    state_d = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                if (tick) begin
                    duty_d = down_duty;
                end
                // Resuming keeps the partly ramped-down duty as the start
                // point; it wins over entering coast on the same edge since
                // the polarity is unchanged.
                if (enable && (direction == dir_q)) begin
                    state_d = RUN;
                end else if (tick && down_to_zero) begin
                    state_d = COAST;
                    coast_d = '0;
                end
            end
            COAST: begin
                duty_d = '0;
                if (tick) begin
                    if (coast_q == COAST_LAST) begin
                        coast_d = '0;
                        if (enable) begin
                            state_d = RUN;
                            dir_d   = direction;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        coast_d = coast_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bridge polarity follows the next state so in3/in4 change on the same
    // edge as state_o; both drop together on entry to COAST or IDLE, so a
    // reversal always passes through the full coast interval.
    always_comb begin
        drive_d = (state_d == RUN) || (state_d == RAMP_DOWN);
    end

    // State and output registers. The PWM compare uses the present state
    // and duty, giving exactly duty_q high cycles per period with one clk
    // of latency; at the RAMP_DOWN->COAST edge cnt is PERIOD-1, which is
    // never below a legal duty, so enb is already low when the bridge opens.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            duty_q  <= '0;
            coast_q <= '0;
            in3_q   <= 1'b0;
            in4_q   <= 1'b0;
            enb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            duty_q  <= duty_d;
            coast_q <= coast_d;
            in3_q   <= drive_d & dir_d;
            in4_q   <= drive_d & ~dir_d;
            enb_q   <= ((state_q == RUN) || (state_q == RAMP_DOWN)) && (cnt < duty_q);
        end
    end

    assign motor_in3    = in3_q;
    assign motor_in4    = in4_q;
    assign motor_enb    = enb_q;
    assign duty_applied = duty_q;
    assign period_tick  = tick;
    assign state_o      = state_q;

endmodule

// File: tb/tb_hbridge_ramp_driver.sv
// ---------------------------------------------------------------------------
// tb_hbridge_ramp_driver
// Directed bench for hbridge_ramp_driver with a short period so the ramp,
// clamp, reversal dead-time, ramp-down abort and mid-run reset can all be
// walked through boundary by boundary against hand-computed values.
// ---------------------------------------------------------------------------
module tb_hbridge_ramp_driver;

    localparam int PERIOD   = 100;
    localparam int SPEED_W  = 7;
    localparam int STEP     = 10;
    localparam int DEADTIME = 3;

    logic               clk;
    logic               rst;
    logic               enable;
    logic               direction;
    logic [SPEED_W-1:0] speed;
    logic               motor_in3;
    logic               motor_in4;
    logic               motor_enb;
    logic [SPEED_W-1:0] duty_applied;
    logic               period_tick;
    logic [1:0]         state_o;

    int checks      = 0;
    int errors      = 0;
    int bothHigh    = 0;
    int enbNoDrive  = 0;

    hbridge_ramp_driver #(
        .PERIOD           (PERIOD),
        .SPEED_W          (SPEED_W),
        .RAMP_STEP        (STEP),
        .DEADTIME_PERIODS (DEADTIME)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .direction    (direction),
        .speed        (speed),
        .motor_in3    (motor_in3),
        .motor_in4    (motor_in4),
        .motor_enb    (motor_enb),
        .duty_applied (duty_applied),
        .period_tick  (period_tick),
        .state_o      (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bridge safety is watched on every cycle for the whole run.
    always @(negedge clk) begin
        if (motor_in3 === 1'b1 && motor_in4 === 1'b1) begin
            bothHigh++;
        end
        if (motor_enb === 1'b1 && motor_in3 !== 1'b1 && motor_in4 !== 1'b1) begin
            enbNoDrive++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic dir, input logic [SPEED_W-1:0] spd);
        enable    = en;
        direction = dir;
        speed     = spd;
    endtask

    // Leaves the bench at the first negedge after the next period boundary.
    task automatic waitBoundary();
        int n;
        n = 0;
        while (period_tick !== 1'b1 && n < 3 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        if (period_tick !== 1'b1) begin
            checkOutput("boundary_timeout", 32'(period_tick), 1);
        end
        @(negedge clk);
    endtask

    // Call right after a boundary; samples one whole period and ends just
    // past the following boundary.
    task automatic countEnb(output int highs);
        highs = 0;
        for (int i = 0; i < PERIOD; i++) begin
            if (motor_enb === 1'b1) begin
                highs++;
            end
            @(negedge clk);
        end
    endtask

    task automatic checkDuty(input string tag, input int expDuty, input int expState);
        waitBoundary();
        checkOutput({tag, "_duty"}, 32'(duty_applied), expDuty);
        checkOutput({tag, "_state"}, 32'(state_o), expState);
    endtask

    initial begin
        int highs;
        int upSeq[5]    = '{10, 20, 30, 40, 50};
        int clampSeq[5] = '{60, 70, 80, 90, 99};
        int backSeq[5]  = '{89, 79, 69, 59, 50};
        int downSeq[4]  = '{40, 30, 20, 10};
        int up2Seq[4]   = '{20, 30, 40, 50};

        // Reset held with enable already requested.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 7'd50);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in3", 32'(motor_in3), 0);
        checkOutput("rst_in4", 32'(motor_in4), 0);
        checkOutput("rst_enb", 32'(motor_enb), 0);
        checkOutput("rst_duty", 32'(duty_applied), 0);
        checkOutput("rst_state", 32'(state_o), 0);
        checkOutput("rst_tick", 32'(period_tick), 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("start_state", 32'(state_o), 1);
        checkOutput("start_in3", 32'(motor_in3), 1);
        checkOutput("start_in4", 32'(motor_in4), 0);

        // Ramp up to 50 in steps of 10, then hold.
        foreach (upSeq[i]) checkDuty("rampup", upSeq[i], 1);
        countEnb(highs);
        checkOutput("enb_high_50", 32'(highs), 50);
        checkOutput("hold_50", 32'(duty_applied), 50);

        // Over-range request clamps to PERIOD-1.
        applyStimulus(1'b1, 1'b1, 7'd127);
        foreach (clampSeq[i]) checkDuty("clamp", clampSeq[i], 1);
        countEnb(highs);
        checkOutput("enb_high_99", 32'(highs), 99);
        checkOutput("hold_99", 32'(duty_applied), 99);

        // Ramp back to 50, last step smaller than RAMP_STEP.
        applyStimulus(1'b1, 1'b1, 7'd50);
        foreach (backSeq[i]) checkDuty("rampback", backSeq[i], 1);

        // Reversal: ramp down with the old polarity, coast, then reverse.
        applyStimulus(1'b1, 1'b0, 7'd50);
        @(negedge clk);
        checkOutput("rev_state", 32'(state_o), 2);
        checkOutput("rev_in3", 32'(motor_in3), 1);
        foreach (downSeq[i]) begin
            checkDuty("revdown", downSeq[i], 2);
            checkOutput("revdown_in3", 32'(motor_in3), 1);
        end
        checkDuty("coast_entry", 0, 3);
        checkOutput("coast_in3", 32'(motor_in3), 0);
        checkOutput("coast_in4", 32'(motor_in4), 0);
        countEnb(highs);
        checkOutput("coast_enb_high", 32'(highs), 0);
        checkOutput("coast_p1_state", 32'(state_o), 3);
        checkDuty("coast_p2", 0, 3);
        checkDuty("coast_exit", 0, 1);
        checkOutput("reversed_in3", 32'(motor_in3), 0);
        checkOutput("reversed_in4", 32'(motor_in4), 1);
        checkDuty("reversed_first", 10, 1);

        // Climb to 50, drop enable for two boundaries, resume without coast.
        foreach (up2Seq[i]) checkDuty("rampup2", up2Seq[i], 1);
        applyStimulus(1'b0, 1'b0, 7'd50);
        @(negedge clk);
        checkOutput("abort_state", 32'(state_o), 2);
        checkDuty("abort_d1", 40, 2);
        checkDuty("abort_d2", 30, 2);
        applyStimulus(1'b1, 1'b0, 7'd50);
        @(negedge clk);
        checkOutput("resume_state", 32'(state_o), 1);
        checkDuty("resume_u1", 40, 1);
        checkDuty("resume_u2", 50, 1);
        checkOutput("resume_in4", 32'(motor_in4), 1);

        // Reset in the middle of a high PWM phase at duty 70.
        applyStimulus(1'b1, 1'b0, 7'd70);
        checkDuty("pre_reset_a", 60, 1);
        checkDuty("pre_reset_b", 70, 1);
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_enb", 32'(motor_enb), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_in3", 32'(motor_in3), 0);
        checkOutput("midrst_in4", 32'(motor_in4), 0);
        checkOutput("midrst_enb", 32'(motor_enb), 0);
        checkOutput("midrst_duty", 32'(duty_applied), 0);
        checkOutput("midrst_state", 32'(state_o), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("never_both_high", 32'(bothHigh), 0);
        checkOutput("enb_without_drive", 32'(enbNoDrive), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
